// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-wide memory, byte/half extraction, read-modify-write sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being force-aligned.
module load_store_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_en,
    output logic [XLEN-1:0]       mem_data_in,
    input  logic [XLEN-1:0]       mem_data_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StMergeWr, StResp} state_t;

    state_t                state_q;
    logic                  write_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       merged_q;
    logic [XLEN-1:0]       rdata_q;
    logic                  error_q;

    logic                  req_bad;
    logic [1:0]            lane_off;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       merged_word;
    logic                  unused_addr;

    // Upper address bits do not reach the word index.
    assign unused_addr = ^req_addr[XLEN-1:ADDR_WIDTH+2];

    always_comb begin
        req_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                  (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
            req_bad = 1'b1;
        end
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
`endif
    end

    // Lane offset after forcing alignment; with traps enabled it is already aligned.
    always_comb begin
        lane_off = addr_q[1:0];
        if (funct3_q[1:0] == 2'b01) begin
            lane_off[0] = 1'b0;
        end else if (funct3_q[1:0] == 2'b10) begin
            lane_off = 2'b00;
        end
    end

    assign lane_byte = mem_data_out[{lane_off, 3'b000} +: 8];
    assign lane_half = mem_data_out[{lane_off[1], 4'b0000} +: 16];

    always_comb begin
        load_data = '0;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, lane_byte};
            3'b001:  load_data = {{(XLEN-16){lane_half[15]}}, lane_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, lane_half};
            3'b010:  load_data = mem_data_out;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = mem_data_out;
        if (funct3_q[1:0] == 2'b00) begin
            merged_word[{lane_off, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_word[{lane_off[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr[ADDR_WIDTH+1:0];
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                        error_q  <= req_bad;
                        state_q  <= req_bad ? StResp : StAccess;
                    end
                end
                StAccess: begin
                    if (!write_q) begin
                        rdata_q <= load_data;
                        state_q <= StResp;
                    end else if (funct3_q[1:0] == 2'b10) begin
                        state_q <= StResp;
                    end else begin
                        merged_q <= merged_word;
                        state_q  <= StMergeWr;
                    end
                end
                StMergeWr: begin
                    state_q <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign resp_valid  = (state_q == StResp);
    assign resp_rdata  = rdata_q;
    assign resp_error  = error_q;
    assign mem_address = addr_q[ADDR_WIDTH+1:2];

    // Write strobe decoded from state so reset removes it without waiting for a clock.
    always_comb begin
        mem_write_en = 1'b0;
        mem_data_in  = '0;
        if ((state_q == StAccess) && write_q && (funct3_q[1:0] == 2'b10)) begin
            mem_write_en = 1'b1;
            mem_data_in  = wdata_q;
        end else if (state_q == StMergeWr) begin
            mem_write_en = 1'b1;
            mem_data_in  = merged_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level memory model.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_address;
    logic        mem_write_en;
    logic [31:0] mem_data_in, mem_data_out;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    int          last_wrs;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .ADDR_WIDTH(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    assign mem_data_out = mem[mem_address];
    always @(posedge clk) if (mem_write_en) mem[mem_address] <= mem_data_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Transaction-level model: result of one request, updating ref_mem for stores.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] e_rd, output logic e_err,
                         output int e_lat, output int e_wrs);
        int          idx;
        int          sz;
        int          off;
        bit          bad;
        logic [31:0] mask;
        logic [31:0] v;
        idx = int'(a[11:2]);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4);
`ifdef MISALIGN_TRAP_EN
        if ((int'(a[1:0]) % sz) != 0) bad = 1'b1;
`endif
        off   = int'(a[1:0]) - (int'(a[1:0]) % sz);
        e_rd  = 32'h0;
        e_err = 1'b0;
        e_wrs = 0;
        if (bad) begin
            e_err = 1'b1;
            e_lat = 1;
        end else if (wr) begin
            if (sz == 4) mask = 32'hFFFF_FFFF;
            else if (sz == 2) mask = 32'h0000_FFFF << (8 * off);
            else mask = 32'h0000_00FF << (8 * off);
            ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << (8 * off)) & mask);
            e_lat = (sz == 4) ? 2 : 3;
            e_wrs = 1;
        end else begin
            v = ref_mem[idx] >> (8 * off);
            if (sz == 1) begin
                v = v & 32'hFF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            e_rd  = v;
            e_lat = 2;
        end
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat, e_wrs, lat, wrs, idx;
        idx = int'(a[11:2]);
        model(wr, f3, a, wd, e_rd, e_err, e_lat, e_wrs);
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        wrs = 0;
        do begin
            @(negedge clk);
            lat++;
            // Junk on the request bus while busy must be ignored.
            req_write  = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            check("req_ready_busy", {31'b0, req_ready}, 32'd0);
            if (mem_write_en) wrs++;
        end while (!resp_valid && lat < 8);
        if (!resp_valid) begin
            $display("FAIL resp_timeout: got no resp_valid after %0d cycles expected %0d", lat, e_lat);
            $fatal(1);
        end
        last_rdata = resp_rdata;
        last_err   = resp_error;
        last_lat   = lat;
        last_wrs   = wrs;
        check("latency", lat, e_lat);
        check("rdata", resp_rdata, e_rd);
        check("error", {31'b0, resp_error}, {31'b0, e_err});
        check("write_count", wrs, e_wrs);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, e_rd);
            check("stall_error", {31'b0, resp_error}, {31'b0, e_err});
            check("stall_no_write", {31'b0, mem_write_en}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_done", {31'b0, resp_valid}, 32'd0);
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_error", {31'b0, resp_error}, 32'd0);
        check("rst_write_en", {31'b0, mem_write_en}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0);
        check("sw_mem4", mem[4], 32'hDEAD_BEEF);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
        check("lw_lit", last_rdata, 32'hDEAD_BEEF);
        do_req(1'b1, 3'd2, 32'h20, 32'h1122_3344, 0);
        do_req(1'b0, 3'd0, 32'h23, 32'h0, 0);
        check("lb23_lit", last_rdata, 32'h0000_0011);
        do_req(1'b1, 3'd0, 32'h21, 32'h0000_00F0, 0);
        check("sb_merge_lit", mem[8], 32'h1122_F044);
        check("sb_lat_lit", last_lat, 32'd3);
        do_req(1'b0, 3'd0, 32'h21, 32'h0, 0);
        check("lb21_lit", last_rdata, 32'hFFFF_FFF0);
        do_req(1'b0, 3'd4, 32'h21, 32'h0, 0);
        check("lbu21_lit", last_rdata, 32'h0000_00F0);
        do_req(1'b1, 3'd2, 32'h30, 32'hCAFE_BABE, 0);
        do_req(1'b1, 3'd1, 32'h32, 32'h0000_8001, 0);
        check("sh_merge_lit", mem[12], 32'h8001_BABE);
        do_req(1'b0, 3'd1, 32'h32, 32'h0, 5);
        check("lh_lit", last_rdata, 32'hFFFF_8001);
        do_req(1'b0, 3'd5, 32'h32, 32'h0, 0);
        check("lhu_lit", last_rdata, 32'h0000_8001);
        do_req(1'b0, 3'd3, 32'h40, 32'h0, 0);
        check("ill_err_lit", {31'b0, last_err}, 32'd1);
        check("ill_lat_lit", last_lat, 32'd1);
        do_req(1'b1, 3'd4, 32'h44, 32'h1234_5678, 0);
        check("ill_st_err_lit", {31'b0, last_err}, 32'd1);
        check("ill_st_wr_lit", last_wrs, 32'd0);
        do_req(1'b1, 3'd2, 32'h4, 32'h5566_7788, 0);
        do_req(1'b0, 3'd2, 32'h6, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
        check("lw6_err_lit", {31'b0, last_err}, 32'd1);
        check("lw6_rdata_lit", last_rdata, 32'h0);
`else
        check("lw6_err_lit", {31'b0, last_err}, 32'd0);
        check("lw6_rdata_lit", last_rdata, 32'h5566_7788);
`endif

        // Reset while the merged word is being written: no partial write may land.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h51; req_wdata = 32'h0000_00AB;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("merge_wr_active", {31'b0, mem_write_en}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_drop_wr", {31'b0, mem_write_en}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_no_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("rst_mem_kept", mem[20], ref_mem[20]);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = {26'($urandom), 6'($urandom)} & 32'h0000_003F;
            do_req(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
